// File: rtl/paillier_result_rx_if.sv
// Stream bundle between the Paillier encryptor result port, the receive buffer and its consumer.
// The slave side is the receive buffer; the master side drives ciphertext words and consumes results.
interface paillier_result_rx_if #(
  parameter int K = 128,
  parameter int N = 32
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [K-1:0]     enc_out_data;
  logic             enc_out_valid;
  logic [K-1:0]     res_data;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic             res_last;
  logic             busy;
  logic             frame_done;
  logic             err_overflow;
  logic             err_clr;

  modport slave (
    input  enc_out_data, enc_out_valid, res_ready, err_clr,
    output res_data, res_valid, res_idx, res_last, busy, frame_done, err_overflow
  );

  modport master (
    output enc_out_data, enc_out_valid, res_ready, err_clr,
    input  res_data, res_valid, res_idx, res_last, busy, frame_done, err_overflow
  );
endinterface

// File: rtl/paillier_result_rx.sv
// Captures one N-word ciphertext frame from the encryptor and replays it over a valid/ready stream.
// Define PAILLIER_RX_MSW_FIRST_EN to drain the frame most-significant word first.
module paillier_result_rx #(
  parameter int K = 128,
  parameter int N = 32
) (
  input logic                clk,
  input logic                rst,
  paillier_result_rx_if.slave io_res
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
`ifdef PAILLIER_RX_MSW_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_RD = LAST_IDX;
  localparam logic [IDX_W-1:0] END_RD   = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_RD = '0;
  localparam logic [IDX_W-1:0] END_RD   = LAST_IDX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [K-1:0]     r_buf [N];
  logic [IDX_W-1:0] r_wr_cnt, r_rd_cnt;
  logic [K-1:0]     r_res_data;
  logic             r_res_valid, r_res_last, r_frame_done, r_err_overflow;
  logic [IDX_W-1:0] r_res_idx;

  logic             w_wr_en, w_last_wr, w_drop, w_accept, w_final_acc;
  logic [IDX_W-1:0] w_rd_step;

  // wr_cnt is always 0 in IDLE, so the first word of a frame lands in buf[0]
  assign w_wr_en     = io_res.enc_out_valid && (r_state != S_DRAIN);
  assign w_last_wr   = w_wr_en && (r_wr_cnt == LAST_IDX);
  assign w_drop      = io_res.enc_out_valid && (r_state == S_DRAIN);
  assign w_accept    = (r_state == S_DRAIN) && r_res_valid && io_res.res_ready;
  assign w_final_acc = w_accept && r_res_last;
`ifdef PAILLIER_RX_MSW_FIRST_EN
  assign w_rd_step   = r_rd_cnt - 1'b1;
`else
  assign w_rd_step   = r_rd_cnt + 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_wr_en) w_state_nxt = w_last_wr ? S_DRAIN : S_COLLECT;
      S_COLLECT: if (w_last_wr) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_final_acc) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Capture buffer: data storage only, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_wr_cnt] <= io_res.enc_out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_res_data     <= '0;
      r_res_valid    <= 1'b0;
      r_res_idx      <= '0;
      r_res_last     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_final_acc;

      if (w_wr_en) r_wr_cnt <= w_last_wr ? '0 : r_wr_cnt + 1'b1;

      // Output register: the first drained word may be the one being written right now
      if (w_last_wr) begin
        r_rd_cnt    <= FIRST_RD;
        r_res_valid <= 1'b1;
        r_res_idx   <= FIRST_RD;
        r_res_last  <= (FIRST_RD == END_RD);
        r_res_data  <= (FIRST_RD == LAST_IDX) ? io_res.enc_out_data : r_buf[FIRST_RD];
      end else if (w_final_acc) begin
        r_rd_cnt    <= '0;
        r_res_valid <= 1'b0;
        r_res_idx   <= '0;
        r_res_last  <= 1'b0;
      end else if (w_accept) begin
        r_rd_cnt    <= w_rd_step;
        r_res_idx   <= w_rd_step;
        r_res_last  <= (w_rd_step == END_RD);
        r_res_data  <= r_buf[w_rd_step];
      end

      if (w_drop)              r_err_overflow <= 1'b1;
      else if (io_res.err_clr) r_err_overflow <= 1'b0;
    end
  end

  assign io_res.res_data     = r_res_data;
  assign io_res.res_valid    = r_res_valid;
  assign io_res.res_idx      = r_res_idx;
  assign io_res.res_last     = r_res_last;
  assign io_res.busy         = (r_state != S_IDLE);
  assign io_res.frame_done   = r_frame_done;
  assign io_res.err_overflow = r_err_overflow;
endmodule

// File: tb/tb_paillier_result_rx.sv
// Bench for paillier_result_rx: directed frames, backpressure, overflow and reset, then random traffic
// checked every cycle against a queue-based frame model.
module tb_paillier_result_rx;
  localparam int K = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paillier_result_rx_if #(.K(K), .N(N)) bus ();
  paillier_result_rx #(.K(K), .N(N)) dut (.clk(clk), .rst(rst), .io_res(bus));

  typedef struct {
    logic [K-1:0] d;
    int           idx;
  } word_t;

  logic [K-1:0] cap_q[$];
  word_t        out_q[$];
  bit           m_err;
  bit           m_done;
  int           n_total = 0;
  int           n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: words accumulate until a full frame, which then becomes the pending output list
  task automatic model_edge();
    bit draining;
    draining = (out_q.size() != 0);
    m_done = 1'b0;
    if (rst) begin
      cap_q.delete();
      out_q.delete();
      m_err = 1'b0;
      return;
    end
    if (draining && bus.res_ready) begin
      m_done = (out_q.size() == 1);
      void'(out_q.pop_front());
    end
    if (bus.enc_out_valid && draining) m_err = 1'b1;
    else if (bus.err_clr)              m_err = 1'b0;
    if (bus.enc_out_valid && !draining) begin
      cap_q.push_back(bus.enc_out_data);
      if (cap_q.size() == N) begin
        for (int i = 0; i < N; i++) begin
          int j;
`ifdef PAILLIER_RX_MSW_FIRST_EN
          j = N - 1 - i;
`else
          j = i;
`endif
          out_q.push_back('{d: cap_q[j], idx: j});
        end
        cap_q.delete();
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".valid"}, 32'(bus.res_valid), 32'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      check({tag, ".data"}, 32'(bus.res_data), 32'(out_q[0].d));
      check({tag, ".idx"},  32'(bus.res_idx),  32'(out_q[0].idx));
      check({tag, ".last"}, 32'(bus.res_last), 32'(out_q.size() == 1));
    end else begin
      check({tag, ".last"}, 32'(bus.res_last), 32'd0);
    end
    if (rst) begin
      check({tag, ".rdata"}, 32'(bus.res_data), 32'd0);
      check({tag, ".ridx"},  32'(bus.res_idx),  32'd0);
    end
    check({tag, ".busy"}, 32'(bus.busy), 32'(cap_q.size() != 0 || out_q.size() != 0));
    check({tag, ".done"}, 32'(bus.frame_done), 32'(m_done));
    check({tag, ".err"},  32'(bus.err_overflow), 32'(m_err));
  endtask

  task automatic drive(input bit v, input logic [K-1:0] d, input bit rdy, input bit clr);
    bus.enc_out_valid = v;
    bus.enc_out_data  = d;
    bus.res_ready     = rdy;
    bus.err_clr       = clr;
  endtask

  task automatic idle(input string tag, input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, rdy, 1'b0);
      cycle(tag);
    end
  endtask

  task automatic send_frame(input string tag, input logic [K-1:0] base, input bit rdy);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, K'(base * (i + 1)), rdy, 1'b0);
      cycle(tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle("reset");
    cycle("reset");
    rst = 1'b0;

    send_frame("basic", 16'h1111, 1'b1);
    idle("basic", 6, 1'b1);

    begin
      bit pat [6] = '{1, 0, 1, 0, 1, 1};
      int w = 0;
      for (int i = 0; i < 6; i++) begin
        drive(pat[i], pat[i] ? K'(16'h1111 * (w + 1)) : '0, 1'b1, 1'b0);
        if (pat[i]) w++;
        cycle("gaps");
      end
      idle("gaps", 6, 1'b1);
    end

    begin
      bit rp [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
      send_frame("bp", 16'h1111, 1'b1);
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, '0, rp[i], 1'b0);
        cycle("bp");
      end
      idle("bp", 2, 1'b1);
    end

    send_frame("ovf", 16'h1111, 1'b0);
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0); cycle("ovf");
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0); cycle("ovf");
    idle("ovf", 6, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1); cycle("clr");
    idle("clr", 2, 1'b1);

    drive(1'b1, 16'h1234, 1'b1, 1'b0); cycle("rstmid");
    drive(1'b1, 16'h5678, 1'b1, 1'b0); cycle("rstmid");
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0); cycle("rstmid");
    rst = 1'b0;
    send_frame("newfrm", 16'h1111 * 5, 1'b1);
    idle("newfrm", 6, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, K'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    idle("tail", 12, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
